// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared definitions for the single-wire serial link, used by
//                both the transmitter and the receiver. Provides the frame
//                state encoding, line-level constants, default frame
//                geometry and a counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    // Frame sequencing states. PARITY is only visited when parity is enabled.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic c_LINE_IDLE = 1'b1;
    localparam logic c_START_BIT = 1'b0;
    localparam logic c_STOP_BIT  = 1'b1;

    localparam int c_DEF_DATA_W       = 8;
    localparam int c_DEF_CLKS_PER_BIT = 16;

    // Width of a counter that must hold 0..n-1; never narrower than 1 bit so
    // that n == 1 still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_tx_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_timer
//  Description : Bit-period timer. Counts 0..CLKS_PER_BIT-1 while enabled and
//                raises tc during the last cycle of each bit period, wrapping
//                back to 0 on that cycle.
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous active-high reset
//                en    - count enable (frame in progress)
//                clr   - synchronous clear to 0
//                tc    - terminal-count pulse (en && count == last)
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_timer
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int                 c_CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;

    // With CLKS_PER_BIT == 1 the counter sits at 0 and tc follows en every cycle.
    assign tc = en && (r_cnt == c_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr || tc) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx
//  Description : Parallel-to-serial transmitter. Accepts a word over a
//                valid/ready handshake and sends start bit, data LSB-first,
//                optional even parity bit and stop bit, each bit held for
//                CLKS_PER_BIT clocks. The line output comes from a register.
//  Options     : SERIAL_TX_PARITY_EN - when defined, an even-parity bit is
//                sent between the last data bit and the stop bit.
//  Ports       : clk      - rising-edge clock
//                reset    - asynchronous active-high reset
//                tx_data  - word to send, sampled on an accepted handshake
//                tx_valid - tx_data is valid
//                tx_ready - idle, a word can be accepted this cycle
//                tx       - serial line, idle high
//                busy     - frame in progress (inverse of tx_ready)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = c_DEF_DATA_W,
    parameter int CLKS_PER_BIT = c_DEF_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy
);

    localparam int                 c_IDX_W    = cnt_width(DATA_W);
    localparam logic [c_IDX_W-1:0] c_LAST_BIT = c_IDX_W'(DATA_W - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    state_t              r_state;
    logic [DATA_W-1:0]   r_shift;
    logic [c_IDX_W-1:0]  r_bit_idx;
    logic                r_tx;
    logic                r_ready;
`ifdef SERIAL_TX_PARITY_EN
    logic                r_parity;
`endif

    logic                w_tc;
    logic                w_accept;
    logic [DATA_W-1:0]   w_shift_nxt;

    assign w_accept    = tx_valid && r_ready;
    assign w_shift_nxt = r_shift >> 1;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .en    (r_state != ST_IDLE),
        .clr   (w_accept),
        .tc    (w_tc)
    );

    // tx is always loaded one cycle ahead with the level of the bit period
    // that starts on the same edge as the state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= c_LINE_IDLE;
            r_ready   <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift   <= tx_data;
                        r_bit_idx <= '0;
                        r_tx      <= c_START_BIT;
                        r_ready   <= 1'b0;
                        r_state   <= ST_START;
`ifdef SERIAL_TX_PARITY_EN
                        r_parity  <= ^tx_data;
`endif
                    end
                end

                ST_START: begin
                    if (w_tc) begin
                        r_tx    <= r_shift[0];
                        r_state <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_tc) begin
                        r_shift <= w_shift_nxt;
                        if (r_bit_idx == c_LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= ST_PARITY;
`else
                            r_tx    <= c_STOP_BIT;
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_tx      <= w_shift_nxt[0];
                            r_bit_idx <= r_bit_idx + c_IDX_ONE;
                        end
                    end
                end

`ifdef SERIAL_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_tc) begin
                        r_tx    <= c_STOP_BIT;
                        r_state <= ST_STOP;
                    end
                end
`endif

                ST_STOP: begin
                    if (w_tc) begin
                        r_tx    <= c_LINE_IDLE;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_tx    <= c_LINE_IDLE;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx       = r_tx;
    assign tx_ready = r_ready;
    assign busy     = ~r_ready;

endmodule
`default_nettype wire
